player_ctrl: RTL and testbench
==============================

# player_ctrl

Front-panel control stage feeding `vga` and the audio decoder. It debounces the four raw push buttons into single-cycle command pulses. It also keeps the saturating volume level and the wrapping song index, and advances the song automatically when the decoder reports end of track. Its outputs drive `vga`'s `i_next`, `i_pre`, `i_vol_plus`, `i_vol_dec` and `vol_level` inputs directly.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- `NUM_SONGS`, default 4: number of tracks. Legal range is 2..256.
- `VOL_RESET`, default 8: volume level loaded at reset.
- `REPEAT_DELAY`, default 50_000_000: hold time before the first auto-repeat (only used with `PLAYER_CTRL_AUTOREPEAT_EN`).
- `REPEAT_RATE`, default 20_000_000: interval between auto-repeat pulses (only used with `PLAYER_CTRL_AUTOREPEAT_EN`).

Ports:
- `CLK`, in, 1: system clock.
- `RST_BTN`, in, 1: reset. One clock; reset is synchronous and active-high.
- `btn_next`, in, 1: raw, asynchronous button input.
- `btn_pre`, in, 1: raw, asynchronous button input.
- `btn_vol_plus`, in, 1: raw, asynchronous button input.
- `btn_vol_dec`, in, 1: raw, asynchronous button input.
- `i_song_done`, in, 1: one-cycle pulse from the decoder at end of track.
- `o_next`, out, 1: one-cycle command pulse.
- `o_pre`, out, 1: one-cycle command pulse.
- `o_vol_plus`, out, 1: one-cycle command pulse.
- `o_vol_dec`, out, 1: one-cycle command pulse.
- `vol_level`, out, 4: current volume, 0..15.
- `song_idx`, out, `$clog2(NUM_SONGS)`: current track.
- `o_song_change`, out, 1: one-cycle pulse in the cycle `song_idx` takes its new value.

## Operation

Each button passes through the same three steps:
- A 2-flop synchronizer.
- A debouncer:
  - It holds a `stable` level and a counter.
  - The counter clears whenever the synchronized input equals `stable`.
  - Otherwise the counter increments.
  - When a mismatch persists for `DEBOUNCE_CYCLES` consecutive cycles, `stable` flips and the counter clears.
  - Glitches shorter than `DEBOUNCE_CYCLES` are ignored.
- A rising edge on `stable` produces one registered `o_*` pulse. Releases produce no pulse.

Command pulses are always forwarded, including when the action is saturated. `vga` uses them for on-screen key feedback.

Volume:
- `o_vol_plus` raises `vol_level` by 1, saturating at 15.
- `o_vol_dec` lowers it by 1, saturating at 0.
- If both pulse in the same cycle, `vol_level` does not change.

Song index:
- `inc = o_next | i_song_done`, `dec = o_pre`.
- `inc` alone: `song_idx` goes to +1, wrapping from `NUM_SONGS-1` to 0.
- `dec` alone: `song_idx` goes to −1, wrapping from 0 to `NUM_SONGS-1`.
- `inc` and `dec` in the same cycle: no change and no `o_song_change`.
- `o_song_change` asserts only when `song_idx` actually changes.

## Timing

- Reset values: all `o_*` pulses 0, `vol_level = VOL_RESET`, `song_idx = 0`, all `stable` levels 0, all counters 0, synchronizers 0.
- Press latency: a raw level that rises before clock edge k and stays high gives an `o_*` pulse high during cycle k+`DEBOUNCE_CYCLES`+3.
  - 2 cycles in the synchronizer.
  - `DEBOUNCE_CYCLES` in the debouncer.
  - 1 cycle to register the pulse.
- `vol_level`, `song_idx` and `o_song_change` update on the clock edge that ends the pulse cycle, i.e. one cycle after the pulse.
- `i_song_done` has 1-cycle latency to `song_idx`.
- Reset mid-debounce: the counter clears. A button still held when reset releases is treated as a new press and pulses `DEBOUNCE_CYCLES`+3 cycles later.
- A button held indefinitely yields exactly one pulse (without auto-repeat).

## Configuration

`PLAYER_CTRL_AUTOREPEAT_EN`:
- Defined:
  - While `btn_vol_plus` or `btn_vol_dec` stays debounced-high, a further pulse is emitted `REPEAT_DELAY` cycles after the initial pulse.
  - After that, pulses repeat every `REPEAT_RATE` cycles until `stable` falls.
  - Each auto-repeat pulse follows the normal volume rules.
  - `btn_next` and `btn_pre` never auto-repeat.
- Undefined: no repeat counters are synthesized; one pulse per press.

## Structure

- Package `player_ctrl_pkg` holds:
  - button index constants `BTN_NEXT=0`, `BTN_PRE=1`, `BTN_VOL_PLUS=2`, `BTN_VOL_DEC=3`;
  - `VOL_MAX=4'd15`, `VOL_MIN=4'd0`.
- Sub-module `btn_debounce`:
  - contains the synchronizer, debouncer and rising-edge pulse;
  - is parameterized by `DEBOUNCE_CYCLES`;
  - is instantiated four times.
- Volume, song-index and auto-repeat logic live in the top level.

## Test plan

All scenarios use `DEBOUNCE_CYCLES=4`, `NUM_SONGS=4`, `VOL_RESET=8`.

1. Reset, then hold `btn_vol_plus` high for 20 cycles. Expect exactly one `o_vol_plus` pulse, exactly 7 cycles after the press, and `vol_level` 8→9.
2. Pulse `btn_next` high for 3 cycles, low, then high again. Expect no `o_next` pulse and `song_idx` stays 0.
3. Perform 10 debounced `vol_plus` presses from reset. Expect `vol_level` to saturate at 15, with 10 `o_vol_plus` pulses observed.
4. From `song_idx=0`, give one `pre` press. Expect `song_idx=3` and one `o_song_change`. Then pulse `i_song_done` once. Expect `song_idx=0`.
5. Force `o_pre` and `i_song_done` into the same cycle. Expect `song_idx` unchanged and no `o_song_change`.
6. Hold `btn_vol_dec` through `RST_BTN` release. Expect a pulse 7 cycles after release and `vol_level=7`.
   - With `PLAYER_CTRL_AUTOREPEAT_EN`, `REPEAT_DELAY=10`, `REPEAT_RATE=5`: additional pulses at +10, +15 and +20 cycles while held.

Source files
------------

// File: rtl/player_ctrl_pkg.sv
// Shared constants and helpers for the front-panel player controller.
// Button indices select lanes of the per-button command vectors.
package player_ctrl_pkg;

  localparam int NUM_BTNS     = 4;
  localparam int BTN_NEXT     = 0;
  localparam int BTN_PRE      = 1;
  localparam int BTN_VOL_PLUS = 2;
  localparam int BTN_VOL_DEC  = 3;

  localparam logic [3:0] VOL_MAX = 4'd15;
  localparam logic [3:0] VOL_MIN = 4'd0;

  // Opposing commands in the same cycle cancel; both ends saturate.
  function automatic logic [3:0] vol_step(input logic [3:0] vol, input logic up, input logic down);
    if (up && !down && vol != VOL_MAX) return vol + 4'd1;
    if (down && !up && vol != VOL_MIN) return vol - 4'd1;
    return vol;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchronizer -> counter debouncer -> registered press pulse.
// With PLAYER_CTRL_AUTOREPEAT_EN the debounced level is also exported.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic srst,
  input  logic raw,
`ifdef PLAYER_CTRL_AUTOREPEAT_EN
  output logic level,
`endif
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_reg;
  logic          sync_reg;
  logic          stable_reg;
  logic          stable_d_reg;
  logic          pulse_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg     <= 1'b0;
      sync_reg     <= 1'b0;
      stable_reg   <= 1'b0;
      stable_d_reg <= 1'b0;
      pulse_reg    <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      meta_reg <= raw;
      sync_reg <= meta_reg;
      // The flip happens on the last of DEBOUNCE_CYCLES consecutive mismatches.
      if (sync_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg <= sync_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      stable_d_reg <= stable_reg;
      pulse_reg    <= stable_reg & ~stable_d_reg;
    end
  end

`ifdef PLAYER_CTRL_AUTOREPEAT_EN
  assign level = stable_reg;
`endif
  assign pulse = pulse_reg;

endmodule

// File: rtl/player_ctrl.sv
// Front-panel control: debounced command pulses, saturating volume, wrapping song index.
// Optional volume auto-repeat is built when PLAYER_CTRL_AUTOREPEAT_EN is defined.
module player_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NUM_SONGS       = 4,
  parameter int VOL_RESET       = 8,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 20_000_000
) (
  input  logic                         CLK,
  input  logic                         RST_BTN,
  input  logic                         btn_next,
  input  logic                         btn_pre,
  input  logic                         btn_vol_plus,
  input  logic                         btn_vol_dec,
  input  logic                         i_song_done,
  output logic                         o_next,
  output logic                         o_pre,
  output logic                         o_vol_plus,
  output logic                         o_vol_dec,
  output logic [3:0]                   vol_level,
  output logic [$clog2(NUM_SONGS)-1:0] song_idx,
  output logic                         o_song_change
);

  localparam int IW = $clog2(NUM_SONGS);
  localparam logic [IW-1:0] SONG_LAST = IW'(NUM_SONGS - 1);

  if (NUM_SONGS < 2 || NUM_SONGS > 256 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_param_check
    $error("player_ctrl: illegal parameter value");
  end

  logic [NUM_BTNS-1:0] raw;
  logic [NUM_BTNS-1:0] deb_pulse;
  logic [NUM_BTNS-1:0] cmd;
  logic [3:0]          vol_reg;
  logic [IW-1:0]       song_reg;
  logic                change_reg;
  logic                inc;
  logic                dec;

  assign raw[BTN_NEXT]     = btn_next;
  assign raw[BTN_PRE]      = btn_pre;
  assign raw[BTN_VOL_PLUS] = btn_vol_plus;
  assign raw[BTN_VOL_DEC]  = btn_vol_dec;

`ifdef PLAYER_CTRL_AUTOREPEAT_EN
  logic [NUM_BTNS-1:0] level;
  logic [NUM_BTNS-1:0] rep_pulse;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk  (CLK),
        .srst (RST_BTN),
        .raw  (raw[gi]),
`ifdef PLAYER_CTRL_AUTOREPEAT_EN
        .level(level[gi]),
`endif
        .pulse(deb_pulse[gi])
      );
    end
  endgenerate

`ifdef PLAYER_CTRL_AUTOREPEAT_EN
  localparam logic [NUM_BTNS-1:0] REP_EN = (NUM_BTNS'(1) << BTN_VOL_PLUS) | (NUM_BTNS'(1) << BTN_VOL_DEC);
  localparam logic [31:0] DELAY_LAST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RATE_LAST  = 32'(REPEAT_RATE - 1);

  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_rep
      logic [31:0] rep_cnt_reg;
      logic        first_reg;
      logic        rep_pulse_reg;

      // rep_cnt_reg counts cycles since the last command pulse on this button.
      always_ff @(posedge CLK) begin
        if (RST_BTN || !level[gi] || !REP_EN[gi]) begin
          rep_cnt_reg   <= '0;
          first_reg     <= 1'b1;
          rep_pulse_reg <= 1'b0;
        end else if (cmd[gi]) begin
          rep_cnt_reg   <= 32'd1;
          rep_pulse_reg <= 1'b0;
        end else begin
          rep_cnt_reg   <= rep_cnt_reg + 32'd1;
          rep_pulse_reg <= (rep_cnt_reg == (first_reg ? DELAY_LAST : RATE_LAST));
          if (rep_cnt_reg == (first_reg ? DELAY_LAST : RATE_LAST)) first_reg <= 1'b0;
        end
      end

      assign rep_pulse[gi] = rep_pulse_reg;
    end
  endgenerate

  assign cmd = deb_pulse | rep_pulse;
`else
  assign cmd = deb_pulse;
`endif

  assign inc = cmd[BTN_NEXT] | i_song_done;
  assign dec = cmd[BTN_PRE];

  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      vol_reg    <= 4'(VOL_RESET);
      song_reg   <= '0;
      change_reg <= 1'b0;
    end else begin
      vol_reg    <= vol_step(vol_reg, cmd[BTN_VOL_PLUS], cmd[BTN_VOL_DEC]);
      change_reg <= inc ^ dec;
      if (inc && !dec) begin
        song_reg <= (song_reg == SONG_LAST) ? '0 : song_reg + 1'b1;
      end else if (dec && !inc) begin
        song_reg <= (song_reg == '0) ? SONG_LAST : song_reg - 1'b1;
      end
    end
  end

  assign o_next        = cmd[BTN_NEXT];
  assign o_pre         = cmd[BTN_PRE];
  assign o_vol_plus    = cmd[BTN_VOL_PLUS];
  assign o_vol_dec     = cmd[BTN_VOL_DEC];
  assign vol_level     = vol_reg;
  assign song_idx      = song_reg;
  assign o_song_change = change_reg;

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: directed scenarios plus a randomized
// command sequence checked against an arithmetic volume/song model.
module tb_player_ctrl;
  import player_ctrl_pkg::*;

  localparam int D  = 4;
  localparam int NS = 4;
  localparam int VR = 8;
  localparam int RD = 10;
  localparam int RR = 5;

  logic       CLK = 1'b0;
  logic       RST_BTN = 1'b1;
  logic       btn_next = 1'b0;
  logic       btn_pre = 1'b0;
  logic       btn_vol_plus = 1'b0;
  logic       btn_vol_dec = 1'b0;
  logic       i_song_done = 1'b0;
  logic       o_next, o_pre, o_vol_plus, o_vol_dec, o_song_change;
  logic [3:0] vol_level;
  logic [1:0] song_idx;

  player_ctrl #(
    .DEBOUNCE_CYCLES(D), .NUM_SONGS(NS), .VOL_RESET(VR),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .CLK(CLK), .RST_BTN(RST_BTN),
    .btn_next(btn_next), .btn_pre(btn_pre),
    .btn_vol_plus(btn_vol_plus), .btn_vol_dec(btn_vol_dec),
    .i_song_done(i_song_done),
    .o_next(o_next), .o_pre(o_pre), .o_vol_plus(o_vol_plus), .o_vol_dec(o_vol_dec),
    .vol_level(vol_level), .song_idx(song_idx), .o_song_change(o_song_change)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor: timestamps of every command pulse, sampled on the falling edge.
  int q_next[$], q_pre[$], q_plus[$], q_dec[$];
  int n_change = 0;
  always @(negedge CLK) begin
    if (o_next)        q_next.push_back(cyc);
    if (o_pre)         q_pre.push_back(cyc);
    if (o_vol_plus)    q_plus.push_back(cyc);
    if (o_vol_dec)     q_dec.push_back(cyc);
    if (o_song_change) n_change++;
  end

  int tests = 0;
  int fails = 0;
  int m_vol = VR;
  int m_idx = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      BTN_NEXT:     btn_next = v;
      BTN_PRE:      btn_pre = v;
      BTN_VOL_PLUS: btn_vol_plus = v;
      default:      btn_vol_dec = v;
    endcase
  endtask

  task automatic press(input int b, input int hold, input int gap, output int e0);
    e0 = cyc;
    set_btn(b, 1'b1);
    tick(hold);
    set_btn(b, 1'b0);
    tick(gap);
    $display("[TB] press btn=%0d hold=%0d -> vol=%0d song=%0d", b, hold, vol_level, song_idx);
  endtask

  task automatic do_reset();
    RST_BTN = 1'b1;
    btn_next = 0; btn_pre = 0; btn_vol_plus = 0; btn_vol_dec = 0; i_song_done = 0;
    tick(3);
    RST_BTN = 1'b0;
    m_vol = VR;
    m_idx = 0;
  endtask

  // Number of pulses a clean press held for `hold` cycles should produce.
  function automatic int exp_pulses(input int b, input int hold);
    int n = 1;
`ifdef PLAYER_CTRL_AUTOREPEAT_EN
    if (b == BTN_VOL_PLUS || b == BTN_VOL_DEC)
      for (int t = D + 3 + RD; t <= hold + D + 2; t += RR) n++;
`endif
    return n;
  endfunction

  function automatic int model_step(input int b, input int n);
    int v = m_vol;
    for (int i = 0; i < n; i++) begin
      if (b == BTN_VOL_PLUS && v < 15) v++;
      if (b == BTN_VOL_DEC && v > 0) v--;
    end
    return v;
  endfunction

  task automatic test_reset();
    do_reset();
    tests++;
    if (vol_level !== 4'(VR)) begin
      fails++; $display("FAIL reset_vol: got %0d want %0d", vol_level, VR);
    end
    tests++;
    if (song_idx !== 2'd0) begin
      fails++; $display("FAIL reset_song: got %0d want 0", song_idx);
    end
    tests++;
    if ({o_next, o_pre, o_vol_plus, o_vol_dec, o_song_change} !== 5'b0) begin
      fails++; $display("FAIL reset_pulses: got %b want 00000",
                        {o_next, o_pre, o_vol_plus, o_vol_dec, o_song_change});
    end
  endtask

  task automatic test_press_latency();
    int base, e0, n;
    do_reset();
    base = q_plus.size();
    press(BTN_VOL_PLUS, 20, 15, e0);
    n = exp_pulses(BTN_VOL_PLUS, 20);
    tests++;
    if (q_plus.size() - base != n) begin
      fails++; $display("FAIL latency_count: got %0d pulses want %0d", q_plus.size() - base, n);
    end
    tests++;
    if (q_plus.size() <= base || q_plus[base] != e0 + D + 3) begin
      fails++; $display("FAIL latency_time: got cycle %0d want %0d",
                        (q_plus.size() > base) ? q_plus[base] - e0 : -1, D + 3);
    end
    m_vol = model_step(BTN_VOL_PLUS, n);
    tests++;
    if (vol_level !== 4'(m_vol)) begin
      fails++; $display("FAIL latency_vol: got %0d want %0d", vol_level, m_vol);
    end
  endtask

  task automatic test_glitch();
    int b0 = q_next.size() + q_pre.size() + q_plus.size() + q_dec.size();
    int c0 = n_change;
    int e0;
    btn_next = 1; tick(3); btn_next = 0; tick(1); btn_next = 1; tick(3); btn_next = 0;
    tick(12);
    for (int i = 0; i < 8; i++)
      press($urandom_range(0, 3), $urandom_range(1, D - 1), $urandom_range(1, 3), e0);
    tick(12);
    tests++;
    if (q_next.size() + q_pre.size() + q_plus.size() + q_dec.size() != b0) begin
      fails++; $display("FAIL glitch_pulses: got %0d new pulses want 0",
                        q_next.size() + q_pre.size() + q_plus.size() + q_dec.size() - b0);
    end
    tests++;
    if (song_idx !== 2'(m_idx) || n_change != c0) begin
      fails++; $display("FAIL glitch_song: got idx %0d changes %0d want idx %0d changes 0",
                        song_idx, n_change - c0, m_idx);
    end
    tests++;
    if (vol_level !== 4'(m_vol)) begin
      fails++; $display("FAIL glitch_vol: got %0d want %0d", vol_level, m_vol);
    end
  endtask

  task automatic test_vol_saturate();
    int base, e0, hold;
    do_reset();
    base = q_plus.size();
    for (int i = 0; i < 10; i++) begin
      hold = $urandom_range(D + 1, D + 5);
      press(BTN_VOL_PLUS, hold, 12, e0);
      m_vol = model_step(BTN_VOL_PLUS, exp_pulses(BTN_VOL_PLUS, hold));
      tests++;
      if (vol_level !== 4'(m_vol)) begin
        fails++; $display("FAIL sat_up_%0d: got %0d want %0d", i, vol_level, m_vol);
      end
    end
    tests++;
    if (q_plus.size() - base != 10 || vol_level !== 4'd15) begin
      fails++; $display("FAIL sat_max: got %0d pulses vol %0d want 10 pulses vol 15",
                        q_plus.size() - base, vol_level);
    end
    base = q_dec.size();
    for (int i = 0; i < 17; i++) begin
      hold = $urandom_range(D + 1, D + 5);
      press(BTN_VOL_DEC, hold, 12, e0);
      m_vol = model_step(BTN_VOL_DEC, exp_pulses(BTN_VOL_DEC, hold));
    end
    tests++;
    if (q_dec.size() - base != 17 || vol_level !== 4'd0) begin
      fails++; $display("FAIL sat_min: got %0d pulses vol %0d want 17 pulses vol 0",
                        q_dec.size() - base, vol_level);
    end
  endtask

  task automatic test_song_wrap();
    int c0, e0;
    do_reset();
    c0 = n_change;
    press(BTN_PRE, 6, 12, e0);
    m_idx = (m_idx + NS - 1) % NS;
    tests++;
    if (song_idx !== 2'(m_idx) || n_change - c0 != 1) begin
      fails++; $display("FAIL wrap_down: got idx %0d changes %0d want idx %0d changes 1",
                        song_idx, n_change - c0, m_idx);
    end
    i_song_done = 1; tick(1); i_song_done = 0;
    m_idx = (m_idx + 1) % NS;
    tests++;
    if (song_idx !== 2'(m_idx) || o_song_change !== 1'b1) begin
      fails++; $display("FAIL wrap_up_done: got idx %0d change %b want idx %0d change 1",
                        song_idx, o_song_change, m_idx);
    end
    tick(2);
    tests++;
    if (n_change - c0 != 2) begin
      fails++; $display("FAIL wrap_changes: got %0d want 2", n_change - c0);
    end
  endtask

  task automatic test_simultaneous();
    int c0 = n_change;
    int p0 = q_plus.size();
    int d0 = q_dec.size();
    btn_pre = 1;
    tick(D + 3);
    tests++;
    if (o_pre !== 1'b1) begin
      fails++; $display("FAIL sim_pre_pulse: got %b want 1", o_pre);
    end
    i_song_done = 1; tick(1); i_song_done = 0;
    btn_pre = 0;
    tick(12);
    tests++;
    if (song_idx !== 2'(m_idx) || n_change != c0) begin
      fails++; $display("FAIL sim_song: got idx %0d changes %0d want idx %0d changes 0",
                        song_idx, n_change - c0, m_idx);
    end
    btn_vol_plus = 1; btn_vol_dec = 1; tick(6);
    btn_vol_plus = 0; btn_vol_dec = 0; tick(12);
    tests++;
    if (vol_level !== 4'(m_vol) || q_plus.size() - p0 != 1 || q_dec.size() - d0 != 1) begin
      fails++; $display("FAIL sim_vol: got vol %0d plus %0d dec %0d want vol %0d plus 1 dec 1",
                        vol_level, q_plus.size() - p0, q_dec.size() - d0, m_vol);
    end
  endtask

  task automatic test_reset_held();
    int base, e0, n, want;
    RST_BTN = 1; btn_vol_dec = 1;
    tick(4);
    RST_BTN = 0;
    m_vol = VR; m_idx = 0;
    base = q_dec.size();
    e0 = cyc;
    tick(23);
    btn_vol_dec = 0;
    tick(15);
    n = exp_pulses(BTN_VOL_DEC, 23);
    tests++;
    if (q_dec.size() - base != n) begin
      fails++; $display("FAIL held_count: got %0d pulses want %0d", q_dec.size() - base, n);
    end
    for (int k = 0; k < n; k++) begin
      want = D + 3 + ((k == 0) ? 0 : RD + (k - 1) * RR);
      tests++;
      if (q_dec.size() <= base + k || q_dec[base + k] - e0 != want) begin
        fails++; $display("FAIL held_time_%0d: got %0d want %0d", k,
                          (q_dec.size() > base + k) ? q_dec[base + k] - e0 : -1, want);
      end
    end
    m_vol = model_step(BTN_VOL_DEC, n);
    tests++;
    if (vol_level !== 4'(m_vol)) begin
      fails++; $display("FAIL held_vol: got %0d want %0d", vol_level, m_vol);
    end
  endtask

  task automatic test_random();
    int op, hold, e0;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 5);
      if (op < 4) begin
        hold = $urandom_range(D + 1, D + 5);
        press(op, hold, 12, e0);
        if (op == BTN_NEXT) m_idx = (m_idx + 1) % NS;
        else if (op == BTN_PRE) m_idx = (m_idx + NS - 1) % NS;
        else m_vol = model_step(op, exp_pulses(op, hold));
      end else if (op == 4) begin
        i_song_done = 1; tick(1); i_song_done = 0; tick(2);
        m_idx = (m_idx + 1) % NS;
        $display("[TB] song_done -> vol=%0d song=%0d", vol_level, song_idx);
      end else begin
        tick(3);
        $display("[TB] idle -> vol=%0d song=%0d", vol_level, song_idx);
      end
      tests++;
      if (vol_level !== 4'(m_vol) || song_idx !== 2'(m_idx)) begin
        fails++; $display("FAIL random_%0d: got vol %0d song %0d want vol %0d song %0d",
                          i, vol_level, song_idx, m_vol, m_idx);
      end
    end
  endtask

  initial begin
    tick(2);
    test_reset();
    test_press_latency();
    test_glitch();
    test_vol_saturate();
    test_song_wrap();
    test_simultaneous();
    test_reset_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
